lsu_req_queue: RTL

Parametrised load/store request unit sitting between the execute stage and the data-SRAM-like bus. It generalises the execute-stage memory interface to DATA_W-bit data and up to DEPTH outstanding requests. It tracks requests in order and formats load data. It raises address-alignment (ALE) responses without bus traffic and discards returns belonging to flushed requests.

---
 rtl/lsu_req_queue.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : lsu_req_queue
// Description : In-order load/store request queue between execute and a
//               data-SRAM-like bus. Formats load data, answers misaligned
//               accesses locally (ALE) and discards returns of flushed ops.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_req_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 37
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [31:0]         in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                flush,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [31:0]         data_sram_addr,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_ale,
    output logic [31:0]         resp_addr,
    output logic [TAG_W-1:0]    resp_tag
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SB = DATA_W / 8;
    localparam int OW = $clog2(SB);
    localparam logic [PW:0] c_DEPTH = (PW+1)'(DEPTH);

    // Queue storage
    logic              r_store [DEPTH];
    logic [1:0]        r_size  [DEPTH];
    logic              r_uns   [DEPTH];
    logic [31:0]       r_addr  [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic              r_ale   [DEPTH];
    logic              r_done  [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];

    // Pointers carry a wrap bit so full and empty are distinguishable
    logic [PW-1:0] r_wr, r_dn, r_rd, r_discard;

    logic [PW-1:0]     w_count, w_pending;
    logic [PW:0]       w_occ;
    logic              w_space, w_mis, w_pop, w_fill;
    logic [AW-1:0]     w_wr_idx, w_dn_idx, w_rd_idx;
    logic [SB-1:0]     w_szmask;
    logic [OW-1:0]     w_off;
    logic [DATA_W-1:0] w_shift, w_mask, w_fmt;
    logic              w_sign;

    assign w_count   = r_wr - r_rd;
    assign w_pending = r_wr - r_dn;
    // Entries still owed a discarded return count against capacity
    assign w_occ     = {1'b0, w_count} + {1'b0, r_discard};
    assign w_space   = (w_occ < c_DEPTH);
    assign w_wr_idx  = r_wr[AW-1:0];
    assign w_dn_idx  = r_dn[AW-1:0];
    assign w_rd_idx  = r_rd[AW-1:0];

    // Alignment check; a dword on a 32-bit bus can never be aligned
    always_comb begin
        w_mis = 1'b0;
        case (in_size)
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = in_addr[0];
            2'd2:    w_mis = |in_addr[1:0];
            default: w_mis = (DATA_W == 32) ? 1'b1 : |in_addr[2:0];
        endcase
    end

    // Bus request side: combinational from the execute-stage op
    assign data_sram_req  = resetn & in_valid & ~w_mis & w_space & ~flush;
    assign in_ready       = resetn & (w_mis ? (in_valid & ~flush & (w_count == '0) & (r_discard == '0))
                                            : (data_sram_req & data_sram_addr_ok));
    assign data_sram_size = in_size;
    assign data_sram_addr = in_addr;
    assign data_sram_wr   = |data_sram_wstrb;

    // Byte enables and lane-replicated store data
    always_comb begin
        w_szmask = '0;
        case (in_size)
            2'd0:    w_szmask = SB'(8'h01);
            2'd1:    w_szmask = SB'(8'h03);
            2'd2:    w_szmask = SB'(8'h0F);
            default: w_szmask = SB'(8'hFF);
        endcase
        data_sram_wstrb = (in_store & ~w_mis) ? (w_szmask << in_addr[OW-1:0]) : '0;
        case (in_size)
            2'd0:    data_sram_wdata = {SB{in_wdata[7:0]}};
            2'd1:    data_sram_wdata = {(SB/2){in_wdata[15:0]}};
            2'd2:    data_sram_wdata = {(SB/4){in_wdata[31:0]}};
            default: data_sram_wdata = in_wdata;
        endcase
    end

    // Load formatting for the entry awaiting data: align, mask, extend
    always_comb begin
        w_off   = r_addr[w_dn_idx][OW-1:0];
        w_shift = data_sram_rdata >> {w_off, 3'b000};
        w_mask  = '1;
        w_sign  = 1'b0;
        case (r_size[w_dn_idx])
            2'd0:    begin w_mask = DATA_W'(8'hFF);        w_sign = w_shift[7];  end
            2'd1:    begin w_mask = DATA_W'(16'hFFFF);     w_sign = w_shift[15]; end
            2'd2:    begin w_mask = DATA_W'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
            default: begin w_mask = '1;                    w_sign = 1'b0;        end
        endcase
        w_fmt = (w_shift & w_mask) | ((w_sign & ~r_uns[w_dn_idx]) ? ~w_mask : '0);
        if (r_store[w_dn_idx]) begin
            w_fmt = '0;
        end
    end

    assign w_fill     = data_sram_data_ok & (r_discard == '0);
    assign resp_valid = r_done[w_rd_idx] & (w_count != '0) & ~flush;
    assign w_pop      = resp_valid & resp_ready;
    assign resp_data  = r_data[w_rd_idx];
    assign resp_ale   = r_ale[w_rd_idx];
    assign resp_addr  = r_addr[w_rd_idx];
    assign resp_tag   = r_tag[w_rd_idx];

    // Pointer and discard-counter update; flush empties the queue at wr
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr      <= '0;
            r_dn      <= '0;
            r_rd      <= '0;
            r_discard <= '0;
        end else if (flush) begin
            r_discard <= PW'(({1'b0, r_discard} + {1'b0, w_pending}) - (PW+1)'(data_sram_data_ok));
            r_dn      <= r_wr;
            r_rd      <= r_wr;
        end else begin
            if (in_ready) begin
                r_wr <= r_wr + 1'b1;
            end
            if (in_ready && w_mis) begin
                r_dn <= r_wr + 1'b1;
            end else if (w_fill) begin
                r_dn <= r_dn + 1'b1;
            end
            if (data_sram_data_ok && (r_discard != '0)) begin
                r_discard <= r_discard - 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    // Entry fields: completion at dn, allocation at wr (allocation wins)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_store[i] <= 1'b0;
                r_size[i]  <= '0;
                r_uns[i]   <= 1'b0;
                r_addr[i]  <= '0;
                r_tag[i]   <= '0;
                r_ale[i]   <= 1'b0;
                r_done[i]  <= 1'b0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_fill) begin
                r_done[w_dn_idx] <= 1'b1;
                r_data[w_dn_idx] <= w_fmt;
            end
            if (in_ready) begin
                r_store[w_wr_idx] <= in_store;
                r_size[w_wr_idx]  <= in_size;
                r_uns[w_wr_idx]   <= in_unsigned;
                r_addr[w_wr_idx]  <= in_addr;
                r_tag[w_wr_idx]   <= in_tag;
                r_ale[w_wr_idx]   <= w_mis;
                r_done[w_wr_idx]  <= w_mis;
                r_data[w_wr_idx]  <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    // A return with nothing outstanding and nothing owed is a bus protocol error
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(data_sram_data_ok && (w_pending == '0) && (r_discard == '0)));
        end
    end
`endif

endmodule
`default_nettype wire
